regfile_scoreboard: RTL

// - Parametrised 2-read/1-write register file with integrated busy-bit scoreboard for the pipelined core.
// - Sits between decode (reads, reserve) and writeback (write); busy flags feed hazard/stall logic.
// - Clocked write, combinational read; register 0 optionally hardwired to zero.

---
 rtl/regfile_scoreboard.sv | 89 ++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read/1-write register file with a busy-bit scoreboard and a registered busy count.
// Defining WRITE_BYPASS_EN forwards the value being written to a same-cycle read of that register.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH+1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   read_reg1,
    input  logic [AW-1:0]   read_reg2,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    output logic            read_busy1,
    output logic            read_busy2,
    input  logic            reserve,
    input  logic [AW-1:0]   reserve_reg,
    input  logic            reg_write,
    input  logic [AW-1:0]   write_reg,
    input  logic [XLEN-1:0] write_data,
    input  logic            flush,
    output logic [CW-1:0]   busy_count
);
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    logic [XLEN-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy, busyNext, wrMask, resMask;
    logic [CW-1:0] countNext;
    logic wrEn, resEn, rdOk1, rdOk2, countUp, countDown;

    // An address is usable when it names a real register that is not the hardwired zero register
    function automatic logic usable(input logic [AW-1:0] a);
        return ({1'b0, a} < LIMIT) && !(ZERO_REG != 0 && a == '0);
    endfunction

    // Decode effective write/reserve and compute the next scoreboard state and count delta
    always_comb begin
        wrEn      = reg_write && usable(write_reg);
        resEn     = reserve && usable(reserve_reg);
        wrMask    = wrEn ? ({{(DEPTH-1){1'b0}}, 1'b1} << write_reg) : '0;
        resMask   = resEn ? ({{(DEPTH-1){1'b0}}, 1'b1} << reserve_reg) : '0;
        busyNext  = flush ? '0 : ((busy & ~wrMask) | resMask);
        countUp   = resEn && !busy[reserve_reg];
        countDown = wrEn && busy[write_reg] && !(resEn && reserve_reg == write_reg);
        countNext = flush ? '0 : busy_count + CW'(countUp) - CW'(countDown);
    end

    // Storage: writes land even during a flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wrEn) begin
            regs[write_reg] <= write_data;
        end
    end

    // Scoreboard bits and their population count, updated together so they never disagree
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busyNext;
            busy_count <= countNext;
        end
    end

    // Combinational read ports; out-of-range and hardwired-zero reads return 0 and not busy
    always_comb begin
        rdOk1      = usable(read_reg1);
        rdOk2      = usable(read_reg2);
        read_data1 = rdOk1 ? regs[read_reg1] : '0;
        read_data2 = rdOk2 ? regs[read_reg2] : '0;
        read_busy1 = rdOk1 && busy[read_reg1];
        read_busy2 = rdOk2 && busy[read_reg2];
`ifdef WRITE_BYPASS_EN
        if (wrEn && write_reg == read_reg1) begin
            read_data1 = write_data;
            read_busy1 = 1'b0;
        end
        if (wrEn && write_reg == read_reg2) begin
            read_data2 = write_data;
            read_busy2 = 1'b0;
        end
`endif
    end
endmodule
